// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the true dual-port SRAM
// Purpose: sequencer state encoding and read-during-write policy selectors.
package sram_pkg;

    // Sequencer states: INIT clears the array, RUN serves port requests.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sram_state_e;

    // Same-port read-during-write policy selectors for RDW_MODE.
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/sram_init_seq.sv
// rtl/sram_init_seq.sv - post-reset array clear sequencer and ready flag
// Purpose: walks every word address once after reset, supplying clear writes,
//          then raises o_ready for the remainder of operation.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   o_ready         registered; high once the array is initialised
//   o_clr_we        clear-write strobe (high throughout INIT)
//   o_clr_addr      word address being cleared this cycle
//   o_clr_data      word written during the clear
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int                ADDR_W        = 15,
    parameter int                DATA_W        = 16,
    parameter int                INIT_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_ready,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic [DATA_W-1:0] o_clr_data
);

    // One extra counter bit so the final address compares cleanly and the
    // increment past it never aliases back onto address 0.
    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    sram_state_e     state;
    logic [ADDR_W:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= (INIT_ON_RESET != 0) ? INIT : RUN;
            cnt     <= '0;
            o_ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state   <= RUN;
                        o_ready <= 1'b1;
                    end
                end
                RUN: begin
                    o_ready <= 1'b1;
                end
                default: begin
                    state   <= RUN;
                    o_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_clr_we   = (state == INIT);
    assign o_clr_addr = cnt[ADDR_W-1:0];
    assign o_clr_data = INIT_VALUE;

endmodule

// File: rtl/sram_tdp.sv
// rtl/sram_tdp.sv - true dual-port byte-lane SRAM with post-reset clear
// Purpose: single-clock 2**ADDR_W x DATA_W array, two independent read/write
//          ports with per-lane write enables and 1-cycle registered reads.
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_en_x, i_we_x, i_be_x           port x request, write select, lane enables
//   i_addr_x, i_data_x               port x word address and write data
//   o_data_x, o_valid_x              port x registered read data and its valid
//   o_ready                          array initialised, requests accepted
module sram_tdp
    import sram_pkg::*;
#(
    parameter int                DATA_W        = 16,
    parameter int                ADDR_W        = 15,
    parameter int                BYTE_W        = 8,
    parameter int                RDW_MODE      = RDW_OLD,
    parameter int                INIT_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en_a,
    input  logic                       i_we_a,
    input  logic [DATA_W/BYTE_W-1:0]   i_be_a,
    input  logic [ADDR_W-1:0]          i_addr_a,
    input  logic [DATA_W-1:0]          i_data_a,
    output logic [DATA_W-1:0]          o_data_a,
    output logic                       o_valid_a,
    input  logic                       i_en_b,
    input  logic                       i_we_b,
    input  logic [DATA_W/BYTE_W-1:0]   i_be_b,
    input  logic [ADDR_W-1:0]          i_addr_b,
    input  logic [DATA_W-1:0]          i_data_b,
    output logic [DATA_W-1:0]          o_data_b,
    output logic                       o_valid_b,
    output logic                       o_ready
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    logic              ready;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;

    sram_init_seq #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .INIT_ON_RESET (INIT_ON_RESET),
        .INIT_VALUE    (INIT_VALUE)
    ) u_init_seq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .o_ready    (ready),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr),
        .o_clr_data (clr_data)
    );

    assign o_ready = ready;

    // The ready register still reads high in the cycle reset is applied, so
    // reset itself also blocks acceptance.
    logic acc_a, acc_b, wr_a, wr_b;
    assign acc_a = i_en_a & ready & ~i_rst;
    assign acc_b = i_en_b & ready & ~i_rst;
    assign wr_a  = acc_a & i_we_a;
    assign wr_b  = acc_b & i_we_b;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] old_a, old_b;
    assign old_a = mem[i_addr_a];
    assign old_b = mem[i_addr_b];

    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] w;
        w = old_word;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) w[k*BYTE_W +: BYTE_W] = new_word[k*BYTE_W +: BYTE_W];
        end
        return w;
    endfunction

    // Port B lanes are applied first so that port A lanes overwrite them on a
    // same-address collision.
    always_ff @(posedge i_clk) begin
        if (clr_we) begin
            mem[clr_addr] <= clr_data;
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (wr_b && i_be_b[k])
                    mem[i_addr_b][k*BYTE_W +: BYTE_W] <= i_data_b[k*BYTE_W +: BYTE_W];
            end
            for (int k = 0; k < NB; k++) begin
                if (wr_a && i_be_a[k])
                    mem[i_addr_a][k*BYTE_W +: BYTE_W] <= i_data_a[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Reads sample the pre-edge array, so cross-port collisions return the
    // old word. A same-port write returns either the old word or its own
    // merged result depending on RDW_MODE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data_a  <= '0;
            o_data_b  <= '0;
            o_valid_a <= 1'b0;
            o_valid_b <= 1'b0;
        end else begin
            o_valid_a <= acc_a;
            o_valid_b <= acc_b;
            if (acc_a)
                o_data_a <= (RDW_MODE == RDW_NEW && i_we_a)
                          ? merge_lanes(old_a, i_data_a, i_be_a) : old_a;
            if (acc_b)
                o_data_b <= (RDW_MODE == RDW_NEW && i_we_b)
                          ? merge_lanes(old_b, i_data_b, i_be_b) : old_b;
        end
    end

endmodule
